mips_cpu_bus_core: RTL and testbench
====================================

Name: mips_cpu_bus_core

Overview:
- Multi-cycle MIPS32 little-endian CPU core with one Avalon-MM-style memory master port, shared by instruction fetch and data access.
- Executes a fixed integer subset starting from the boot vector.
- Exposes $v0 and an "active" flag so a system or bench can detect completion.
- Sits between the top-level bus and a word-addressed RAM.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- active  out  1  high while executing; low once halted
- register_v0  out  32  live contents of GPR 2 ($v0)
- address  out  32  byte address of the bus transfer, always word-aligned
- write  out  1  write request
- read  out  1  read request
- waitrequest  in  1  slave stall; the master holds its request while high
- writedata  out  32  store data
- byteenable  out  4  byte lanes; 4'b1111 for all supported accesses
- readdata  in  32  read data, valid on the cycle read=1 and waitrequest=0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at a rising edge):
  - PC=RESET_VECTOR, all GPRs=0, state=FETCH, active=1.
  - No delay-slot jump is pending.
- First bus request: in the cycle right after the reset edge (reset may still be high), address=BFC00000, read=1, write=0, byteenable=1111.
- Bus outputs are combinational from state and registers. read and write are never both high.
- Handshake:
  - A request completes on a rising edge where waitrequest=0.
  - While waitrequest=1 the state holds and address, read, write, writedata and byteenable stay stable.
- States:
  - FETCH: read=1, address=PC. On completion, latch readdata into IR and go to EXEC.
  - EXEC: decode and compute. ALU or branch instructions write back and go to FETCH. LW and SW go to MEM.
  - MEM: LW drives read=1 with address=rs+sext(imm) and writes readdata to rt on completion. SW drives write=1 with writedata=rt and the same address form. Both then go to FETCH.
  - HALTED: active=0, read=0, write=0. Stays here until reset.
- Minimum instruction latency: 2 cycles for ALU and branch instructions, 3 cycles for LW and SW, plus any wait cycles.
- Instruction set:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR.
  - I-type: ADDIU, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE.
  - Arithmetic wraps modulo 2^32 with no overflow exceptions.
  - ANDI, ORI and XORI zero-extend the immediate; the other I-types sign-extend it.
  - LUI writes imm<<16.
- Branch delay slot: BEQ, BNE and JR execute the following instruction before the PC changes.
  - Branch target = PC_of_branch + 4 + (sext(imm)<<2).
  - A branch in a delay slot is undefined and is not required to work.
- Register $0 always reads 0; writes to it are discarded.
- Halt: when a JR whose target is 0x00000000 completes its delay slot, go to HALTED instead of fetching, and deassert active in the same cycle.
- Unsupported opcodes execute as NOP.
- Misaligned LW/SW addresses are undefined behaviour.
- Reset asserted mid-operation (any state) aborts the current transfer and re-enters the reset condition at that edge.
- register_v0 is valid at all times and must still hold its final value after halt.

Decomposition:
- Package mips_cpu_pkg holds:
  - opcode and funct constants;
  - the state enum {FETCH, EXEC, MEM, HALTED};
  - RESET_VECTOR default.
- Sub-module mips_cpu_regfile: 32x32 register file with two combinational read ports, one synchronous write port, $0 hardwired to zero, and a dedicated v0 output.
- The ALU and control logic stay inline in the core.

Test Plan:
- Reset: assert reset one cycle, then release. At the next falling edge require active=1, address=BFC00000, read=1, write=0, byteenable=1111.
- LUI/ORI into v0, then JR $0 with a NOP in the delay slot. Program: LUI v0,0x1234; ORI v0,v0,0x5678; JR zero; NOP. Require v0=0x12345678 and active falling to 0 within 20 cycles.
- LW/SW round trip. Program: LUI v1,0xBFC0; LW t1,0x28(v1), where RAM holds 0xDEADBEEF; LW t2,0x2C(v1), where RAM holds 0x00001000; SW t1,0(t2); LW v0,0(t2). Require a write cycle at address 0x1000 with data DEADBEEF, and final v0=DEADBEEF.
- Waitrequest: RAM model asserts waitrequest for 3 cycles on every access. Require address, read and write stable throughout, and the same final v0 as the unstalled run.
- Branch plus delay slot. Program: ADDIU v0,zero,1; BEQ zero,zero,+2; ADDIU v0,v0,2 (delay slot); ADDIU v0,v0,4 (skipped); ADDIU v0,v0,8; then halt. Require v0=11.
- Reset mid-run: assert reset during a stalled MEM write. Require write to drop, the next request to be a fetch from BFC00000, and GPRs cleared.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared opcode/funct encodings, FSM state type and reset vector for the
// multi-cycle MIPS32 bus core.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM,
        HALTED
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_cpu_regfile.sv
// 32x32 GPR file: two combinational read ports, one synchronous write port,
// $0 reads as zero, and a dedicated $v0 tap.
module mips_cpu_regfile (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] v0_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '{default: '0};
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rs_data_o = (rs_addr_i == 5'd0) ? '0 : regs_q[rs_addr_i];
    assign rt_data_o = (rt_addr_i == 5'd0) ? '0 : regs_q[rt_addr_i];
    assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_cpu_bus_core.sv
// Multi-cycle MIPS32 core (FETCH/EXEC/MEM) with a single Avalon-MM style
// master shared by instruction fetch and data access.
module mips_cpu_bus_core
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_tgt_q, br_tgt_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_sx, imm_zx;
    logic [31:0] rs_val, rt_val;
    logic [31:0] mem_addr;
    logic        is_lw, is_sw;

    logic [31:0] alu_res;
    logic [4:0]  alu_wa;
    logic        alu_we;
    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        retire;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];
    assign imm_sx = sext16(imm);
    assign imm_zx = {16'h0000, imm};

    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign mem_addr = rs_val + imm_sx;

    mips_cpu_regfile u_regfile (
        .clk_i     (clk),
        .reset_i   (reset),
        .rs_addr_i (rs),
        .rt_addr_i (rt),
        .rs_data_o (rs_val),
        .rt_data_o (rt_val),
        .we_i      (rf_we),
        .wa_i      (rf_wa),
        .wd_i      (rf_wd),
        .v0_o      (register_v0)
    );

    // Decode/execute of the IR; unsupported encodings fall through as NOPs.
    always_comb begin
        alu_res      = '0;
        alu_wa       = rt;
        alu_we       = 1'b0;
        redirect     = 1'b0;
        redirect_tgt = '0;
        case (opcode)
            OP_SPECIAL: begin
                alu_wa = rd;
                case (funct)
                    FN_ADDU: begin alu_res = rs_val + rt_val; alu_we = 1'b1; end
                    FN_SUBU: begin alu_res = rs_val - rt_val; alu_we = 1'b1; end
                    FN_AND:  begin alu_res = rs_val & rt_val; alu_we = 1'b1; end
                    FN_OR:   begin alu_res = rs_val | rt_val; alu_we = 1'b1; end
                    FN_XOR:  begin alu_res = rs_val ^ rt_val; alu_we = 1'b1; end
                    FN_SLT: begin
                        alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
                        alu_we  = 1'b1;
                    end
                    FN_SLTU: begin
                        alu_res = {31'd0, rs_val < rt_val};
                        alu_we  = 1'b1;
                    end
                    FN_SLL: begin alu_res = rt_val << shamt; alu_we = 1'b1; end
                    FN_SRL: begin alu_res = rt_val >> shamt; alu_we = 1'b1; end
                    FN_SRA: begin
                        alu_res = $unsigned($signed(rt_val) >>> shamt);
                        alu_we  = 1'b1;
                    end
                    FN_JR: begin
                        redirect     = 1'b1;
                        redirect_tgt = rs_val;
                    end
                    default: ;
                endcase
            end
            OP_ADDIU: begin alu_res = rs_val + imm_sx; alu_we = 1'b1; end
            OP_SLTIU: begin alu_res = {31'd0, rs_val < imm_sx}; alu_we = 1'b1; end
            OP_ANDI:  begin alu_res = rs_val & imm_zx; alu_we = 1'b1; end
            OP_ORI:   begin alu_res = rs_val | imm_zx; alu_we = 1'b1; end
            OP_XORI:  begin alu_res = rs_val ^ imm_zx; alu_we = 1'b1; end
            OP_LUI:   begin alu_res = {imm, 16'h0000}; alu_we = 1'b1; end
            OP_BEQ: begin
                redirect     = (rs_val == rt_val);
                redirect_tgt = pc_q + 32'd4 + {imm_sx[29:0], 2'b00};
            end
            OP_BNE: begin
                redirect     = (rs_val != rt_val);
                redirect_tgt = pc_q + 32'd4 + {imm_sx[29:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        unique case (state_q)
            FETCH: begin
                read    = 1'b1;
                address = pc_q;
            end
            MEM: begin
                read      = is_lw;
                write     = is_sw;
                address   = {mem_addr[31:2], 2'b00};
                writedata = is_sw ? rt_val : '0;
            end
            EXEC, HALTED: ;
        endcase
    end

    assign byteenable = '1;
    assign active     = (state_q != HALTED);

    assign rf_we = ((state_q == EXEC) && alu_we)
                 || ((state_q == MEM) && is_lw && !waitrequest);
    assign rf_wa = (state_q == MEM) ? rt : alu_wa;
    assign rf_wd = (state_q == MEM) ? readdata : alu_res;

    // A taken branch/JR only arms a pending redirect; it is applied when the
    // following (delay-slot) instruction retires, or halts if the target is 0.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        br_pend_d = br_pend_q;
        br_tgt_d  = br_tgt_q;
        retire    = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (!waitrequest) begin
                    ir_d    = readdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = MEM;
                end else begin
                    retire = 1'b1;
                end
            end
            MEM: begin
                if (!waitrequest) begin
                    retire = 1'b1;
                end
            end
            HALTED: ;
        endcase
        if (retire) begin
            br_pend_d = redirect;
            br_tgt_d  = redirect_tgt;
            if (br_pend_q && (br_tgt_q == '0)) begin
                state_d = HALTED;
            end else begin
                state_d = FETCH;
                pc_d    = br_pend_q ? br_tgt_q : pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_VECTOR;
            ir_q      <= '0;
            br_pend_q <= 1'b0;
            br_tgt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            br_pend_q <= br_pend_d;
            br_tgt_q  <= br_tgt_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Bench for mips_cpu_bus_core: directed programs plus random programs checked
// against an instruction-level MIPS interpreter.
module tb_mips_cpu_bus_core;

    localparam logic [31:0] BOOT = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = '0;

    mips_cpu_bus_core #(.RESET_VECTOR(BOOT)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // ---------------- bus slave RAM ----------------
    logic [31:0] ram  [logic [29:0]];
    logic [31:0] mmem [logic [29:0]];
    logic [31:0] qgot_a[$], qgot_d[$], qexp_a[$], qexp_d[$];
    int unsigned stall_cfg = 0;
    int unsigned wait_left = 0;
    bit          fresh = 1'b1;
    bit          pend_commit = 1'b0;
    bit          pend_wr = 1'b0;
    logic [31:0] pend_a, pend_d;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [1:0]  prev_rw;
    logic [3:0]  prev_be;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a[31:2])) return ram[a[31:2]];
        return '0;
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (mmem.exists(a[31:2])) return mmem[a[31:2]];
        return '0;
    endfunction

    always @(negedge clk) begin
        if (prev_stall) begin
            check("stable_addr", address, prev_addr);
            check("stable_rw", {30'd0, read, write}, {30'd0, prev_rw});
            check("stable_wdata", writedata, prev_wdata);
            check("stable_be", {28'd0, byteenable}, {28'd0, prev_be});
        end
        if (read === 1'b1 || write === 1'b1) begin
            if (fresh) begin
                wait_left = stall_cfg;
                fresh = 1'b0;
            end
            waitrequest = (wait_left != 0);
            if (wait_left != 0) wait_left--;
            readdata    = ram_rd(address);
            pend_commit = !waitrequest;
            pend_wr     = (write === 1'b1);
            pend_a      = address;
            pend_d      = writedata;
            prev_stall  = waitrequest;
            prev_addr   = address;
            prev_rw     = {read, write};
            prev_wdata  = writedata;
            prev_be     = byteenable;
        end else begin
            waitrequest = 1'b0;
            pend_commit = 1'b0;
            prev_stall  = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            fresh = 1'b1;
            prev_stall = 1'b0;
        end else if (pend_commit) begin
            if (pend_wr) begin
                ram[pend_a[31:2]] = pend_d;
                qgot_a.push_back(pend_a);
                qgot_d.push_back(pend_d);
            end
            fresh = 1'b1;
        end
        pend_commit = 1'b0;
    end

    // ---------------- program construction ----------------
    int unsigned pidx = 0;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put(input logic [31:0] w);
        logic [31:0] a;
        a = BOOT + 32'(pidx * 4);
        ram[a[31:2]] = w;
        pidx++;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        ram[a[31:2]] = w;
    endtask

    task automatic new_image();
        ram.delete();
        pidx = 0;
    endtask

    task automatic put_halt();
        put(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        put(32'd0);
    endtask

    // ---------------- ISA-level reference model ----------------
    logic [31:0] mregs [32];

    task automatic setr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) mregs[r] = v;
    endtask

    task automatic model_run(output logic [31:0] v0);
        logic [31:0] pc, npc, nnpc, ins, a, b, simm, zimm, ea;
        logic [4:0]  rs, rt, rd, sh;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        qexp_a.delete();
        qexp_d.delete();
        pc  = BOOT;
        npc = BOOT + 32'd4;
        for (int n = 0; n < 5000; n++) begin
            if (pc == 32'd0) break;
            ins  = mrd(pc);
            rs   = ins[25:21];
            rt   = ins[20:16];
            rd   = ins[15:11];
            sh   = ins[10:6];
            a    = mregs[rs];
            b    = mregs[rt];
            simm = {{16{ins[15]}}, ins[15:0]};
            zimm = {16'd0, ins[15:0]};
            nnpc = npc + 32'd4;
            case (ins[31:26])
                6'h00: case (ins[5:0])
                    6'h21: setr(rd, a + b);
                    6'h23: setr(rd, a - b);
                    6'h24: setr(rd, a & b);
                    6'h25: setr(rd, a | b);
                    6'h26: setr(rd, a ^ b);
                    6'h2A: setr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    6'h2B: setr(rd, (a < b) ? 32'd1 : 32'd0);
                    6'h00: setr(rd, b << sh);
                    6'h02: setr(rd, b >> sh);
                    6'h03: setr(rd, $unsigned($signed(b) >>> sh));
                    6'h08: nnpc = a;
                    default: ;
                endcase
                6'h04: if (a == b) nnpc = npc + (simm << 2);
                6'h05: if (a != b) nnpc = npc + (simm << 2);
                6'h09: setr(rt, a + simm);
                6'h0B: setr(rt, (a < simm) ? 32'd1 : 32'd0);
                6'h0C: setr(rt, a & zimm);
                6'h0D: setr(rt, a | zimm);
                6'h0E: setr(rt, a ^ zimm);
                6'h0F: setr(rt, {ins[15:0], 16'd0});
                6'h23: setr(rt, mrd(a + simm));
                6'h2B: begin
                    ea = a + simm;
                    mmem[ea[31:2]] = b;
                    qexp_a.push_back({ea[31:2], 2'b00});
                    qexp_d.push_back(b);
                end
                default: ;
            endcase
            pc  = npc;
            npc = nnpc;
        end
        v0 = mregs[2];
    endtask

    // ---------------- DUT run control ----------------
    task automatic apply_reset();
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
    endtask

    task automatic run_dut(input int unsigned stall, input int unsigned budget,
                           output int unsigned cycles);
        stall_cfg = stall;
        qgot_a.delete();
        qgot_d.delete();
        apply_reset();
        cycles = 0;
        while (active === 1'b1 && cycles < budget) begin
            @(negedge clk); #1;
            cycles++;
        end
        check("halted", {31'd0, active}, 32'd0);
    endtask

    task automatic load_lwsw();
        new_image();
        put(enc_i(6'h0F, 5'd0, 5'd3, 16'hBFC0));
        put(enc_i(6'h23, 5'd3, 5'd9, 16'h0028));
        put(enc_i(6'h23, 5'd3, 5'd10, 16'h002C));
        put(enc_i(6'h2B, 5'd10, 5'd9, 16'h0000));
        put(enc_i(6'h23, 5'd10, 5'd2, 16'h0000));
        put_halt();
        poke(32'hBFC0_0028, 32'hDEAD_BEEF);
        poke(32'hBFC0_002C, 32'h0000_1000);
    endtask

    function automatic logic [4:0] rsrc();
        return 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [4:0] rdst();
        logic [4:0] r;
        do r = 5'($urandom_range(0, 15)); while (r == 5'd8);
        return r;
    endfunction

    // r8 is a fixed data base at 0x2000; the epilogue dumps r1..r15 to 0x2080+.
    task automatic gen_random();
        localparam int unsigned B = 24;
        logic [5:0] fns [10];
        logic [5:0] iops [5];
        bit prev_br;
        int unsigned kind, off;
        fns  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        iops = '{6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
        new_image();
        for (int unsigned k = 0; k < 48; k++) poke(32'h2000 + 32'(k * 4), $urandom());
        put(enc_i(6'h09, 5'd0, 5'd8, 16'h2000));
        prev_br = 1'b0;
        for (int unsigned p = 1; p <= B; p++) begin
            kind = $urandom_range(0, 9);
            if (kind == 8 && (prev_br || p == B)) kind = 3;
            prev_br = 1'b0;
            case (kind)
                0, 1, 2: put(enc_r(rsrc(), rsrc(), rdst(), 5'($urandom_range(0, 31)),
                                   fns[$urandom_range(0, 9)]));
                3, 4: put(enc_i(iops[$urandom_range(0, 4)], rsrc(), rdst(), 16'($urandom())));
                5: put(enc_i(6'h0F, 5'd0, rdst(), 16'($urandom())));
                6: put(enc_i(6'h23, 5'd8, rdst(), 16'($urandom_range(0, 15) * 4)));
                7: put(enc_i(6'h2B, 5'd8, rsrc(), 16'($urandom_range(0, 15) * 4)));
                8: begin
                    off = $urandom_range(1, (B - p < 3) ? B - p : 3);
                    put(enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05,
                              rsrc(), rsrc(), 16'(off)));
                    prev_br = 1'b1;
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) put({6'h3F, 26'($urandom())});
                    else put(enc_r(rsrc(), rsrc(), rdst(), 5'd0, 6'h3F));
                end
            endcase
        end
        for (int unsigned r = 1; r < 16; r++)
            put(enc_i(6'h2B, 5'd8, 5'(r), 16'(32'h80 + r * 4)));
        put_halt();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned cyc;
        bit          found;
        logic [31:0] mv0;
        int unsigned nw;

        // Reset and first fetch request
        new_image();
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); #1;
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_addr", address, BOOT);
        check("rst_read", {31'd0, read}, 32'd1);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_be", {28'd0, byteenable}, 32'hF);
        reset = 1'b0;

        // LUI/ORI into v0 then halt
        new_image();
        put(enc_i(6'h0F, 5'd0, 5'd2, 16'h1234));
        put(enc_i(6'h0D, 5'd2, 5'd2, 16'h5678));
        put_halt();
        run_dut(0, 100, cyc);
        check("luiori_v0", register_v0, 32'h1234_5678);
        check("luiori_latency", {31'd0, cyc <= 20}, 32'd1);

        // LW/SW round trip, unstalled then with 3 wait cycles per access
        for (int unsigned s = 0; s < 2; s++) begin
            load_lwsw();
            run_dut((s == 0) ? 0 : 3, 500, cyc);
            check("lwsw_v0", register_v0, 32'hDEAD_BEEF);
            check("lwsw_nwrites", 32'(qgot_a.size()), 32'd1);
            if (qgot_a.size() > 0) begin
                check("lwsw_waddr", qgot_a[0], 32'h0000_1000);
                check("lwsw_wdata", qgot_d[0], 32'hDEAD_BEEF);
            end
        end

        // Branch with delay slot
        new_image();
        put(enc_i(6'h09, 5'd0, 5'd2, 16'd1));
        put(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
        put(enc_i(6'h09, 5'd2, 5'd2, 16'd2));
        put(enc_i(6'h09, 5'd2, 5'd2, 16'd4));
        put(enc_i(6'h09, 5'd2, 5'd2, 16'd8));
        put_halt();
        run_dut(0, 100, cyc);
        check("branch_v0", register_v0, 32'd11);

        // Reset during a stalled store
        new_image();
        put(enc_i(6'h0F, 5'd0, 5'd2, 16'h1234));
        put(enc_i(6'h09, 5'd0, 5'd8, 16'h2000));
        put(enc_i(6'h2B, 5'd8, 5'd2, 16'h0000));
        put_halt();
        poke(32'h2000, 32'd0);
        stall_cfg = 3;
        apply_reset();
        found = 1'b0;
        for (int unsigned c = 0; c < 200 && !found; c++) begin
            @(negedge clk); #1;
            if (write === 1'b1 && waitrequest === 1'b1) found = 1'b1;
        end
        check("midrst_found", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        check("midrst_write", {31'd0, write}, 32'd0);
        check("midrst_read", {31'd0, read}, 32'd1);
        check("midrst_addr", address, BOOT);
        check("midrst_v0", register_v0, 32'd0);
        check("midrst_nostore", ram_rd(32'h2000), 32'd0);
        reset = 1'b0;

        // Random programs against the reference interpreter
        for (int unsigned t = 0; t < 8; t++) begin
            gen_random();
            mmem = ram;
            model_run(mv0);
            run_dut($urandom_range(0, 2), 4000, cyc);
            check("rand_v0", register_v0, mv0);
            check("rand_nwrites", 32'(qgot_a.size()), 32'(qexp_a.size()));
            nw = (qgot_a.size() < qexp_a.size()) ? qgot_a.size() : qexp_a.size();
            for (int unsigned k = 0; k < nw; k++) begin
                check("rand_waddr", qgot_a[k], qexp_a[k]);
                check("rand_wdata", qgot_d[k], qexp_d[k]);
            end
            for (int unsigned k = 0; k < 48; k++)
                check("rand_ram", ram_rd(32'h2000 + 32'(k * 4)), mrd(32'h2000 + 32'(k * 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
